// File: rtl/vec_mac_pipe.sv
// vec_mac_pipe: multi-lane integer multiply / multiply-accumulate unit.
// Lane results are formed at the input and then carried through STAGES valid/ready registers.
package vec_mac_pkg;
  localparam logic [5:0] FN_MUL    = 6'd10;
  localparam logic [5:0] FN_MULH   = 6'd11;
  localparam logic [5:0] FN_MULHSU = 6'd12;
  localparam logic [5:0] FN_MULHU  = 6'd13;
  localparam logic [5:0] FN_MACC   = 6'd16;
  localparam logic [5:0] FN_NMSAC  = 6'd17;
  localparam logic [5:0] FN_MADD   = 6'd18;
  localparam logic [5:0] FN_NMSUB  = 6'd19;
endpackage

module vec_mac_lane
  import vec_mac_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [5:0]      fn,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] c,
  input  logic            en,
  output logic [XLEN-1:0] res
);

  logic              swap;
  logic              m_sx;
  logic              b_sx;
  logic              is_hi;
  logic              is_acc;
  logic              is_sub;
  logic [XLEN-1:0]   m;
  logic [XLEN-1:0]   d;
  logic [XLEN-1:0]   lo;
  logic [XLEN-1:0]   hi;
  logic [2*XLEN-1:0] mx;
  logic [2*XLEN-1:0] bx;
  logic [2*XLEN-1:0] prod;

  assign swap   = (fn == FN_MADD) | (fn == FN_NMSUB);
  assign m_sx   = (fn == FN_MULH) | (fn == FN_MULHSU);
  assign b_sx   = (fn == FN_MULH);
  assign is_hi  = (fn == FN_MULH) | (fn == FN_MULHSU)
                | (fn == FN_MULHU);
  assign is_acc = (fn == FN_MACC) | (fn == FN_MADD);
  assign is_sub = (fn == FN_NMSAC) | (fn == FN_NMSUB);

  assign m = swap ? c : a;
  assign d = swap ? a : c;

  // Sign-extend to 2*XLEN so one unsigned multiplier covers all signedness mixes.
  assign mx = {{XLEN{m_sx & m[XLEN-1]}}, m};
  assign bx = {{XLEN{b_sx & b[XLEN-1]}}, b};

  assign prod = mx * bx;
  assign lo   = prod[XLEN-1:0];
  assign hi   = prod[2*XLEN-1:XLEN];

  always_comb begin
    res = '0;
    unique case (1'b1)
      is_hi:   res = hi;
      is_acc:  res = d + lo;
      is_sub:  res = d - lo;
      default: res = lo;
    endcase
    if (!en) res = '0;
  end

endmodule

module vec_mac_pipe
  import vec_mac_pkg::*;
#(
  parameter int NUM_LANE = 8,
  parameter int XLEN     = 32,
  parameter int STAGES   = 2,
  parameter int CW       = 8,
  parameter int WID_W    = 3,
  localparam int OW      = $clog2(STAGES + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [NUM_LANE*XLEN-1:0] a_i,
  input  logic [NUM_LANE*XLEN-1:0] b_i,
  input  logic [NUM_LANE*XLEN-1:0] c_i,
  input  logic [NUM_LANE-1:0]      mask_i,
  input  logic [5:0]               ctrl_alu_fn_i,
  input  logic [CW-1:0]            ctrl_reg_idxw_i,
  input  logic [WID_W-1:0]         ctrl_wid_i,
  input  logic                     ctrl_wvd_i,
  input  logic                     ctrl_wxd_i,
  input  logic                     flush_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [NUM_LANE*XLEN-1:0] result_o,
  output logic [NUM_LANE-1:0]      mask_o,
  output logic [5:0]               ctrl_alu_fn_o,
  output logic [CW-1:0]            ctrl_reg_idxw_o,
  output logic [WID_W-1:0]         ctrl_wid_o,
  output logic                     ctrl_wvd_o,
  output logic                     ctrl_wxd_o,
  output logic [OW-1:0]            occupancy_o
);

  typedef struct packed {
    logic [NUM_LANE*XLEN-1:0] res;
    logic [NUM_LANE-1:0]      mask;
    logic [5:0]               fn;
    logic [CW-1:0]            idx;
    logic [WID_W-1:0]         wid;
    logic                     wvd;
    logic                     wxd;
  } stage_t;

  logic [NUM_LANE*XLEN-1:0] lane_res;
  stage_t                   st_in;
  stage_t                   st_q [STAGES];
  logic [STAGES-1:0]        v_q;
  logic [STAGES-1:0]        adv;
  logic                     hole;
  logic                     accept;
  logic [OW-1:0]            occ;

  for (genvar k = 0; k < NUM_LANE; k++) begin : g_lane
    vec_mac_lane #(
      .XLEN (XLEN)
    ) u_lane (
      .fn  (ctrl_alu_fn_i),
      .a   (a_i[k*XLEN +: XLEN]),
      .b   (b_i[k*XLEN +: XLEN]),
      .c   (c_i[k*XLEN +: XLEN]),
      .en  (mask_i[k]),
      .res (lane_res[k*XLEN +: XLEN])
    );
  end

  assign st_in.res  = lane_res;
  assign st_in.mask = mask_i;
  assign st_in.fn   = ctrl_alu_fn_i;
  assign st_in.idx  = ctrl_reg_idxw_i;
  assign st_in.wid  = ctrl_wid_i;
  assign st_in.wvd  = ctrl_wvd_i;
  assign st_in.wxd  = ctrl_wxd_i;

  // A stage may advance if any stage from it to the output is empty.
  always_comb begin
    adv  = '0;
    hole = out_ready_i;
    for (int s = STAGES - 1; s >= 0; s--) begin
      hole   = hole | ~v_q[s];
      adv[s] = hole;
    end
  end

  assign in_ready_o = adv[0] & ~flush_i;
  assign accept     = in_valid_i & in_ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        st_q[s] <= '0;
      end
    end else if (flush_i) begin
      v_q <= '0;
    end else begin
      if (adv[0]) begin
        v_q[0] <= accept;
        if (accept) st_q[0] <= st_in;
      end
      for (int s = 1; s < STAGES; s++) begin
        if (adv[s]) begin
          v_q[s] <= v_q[s-1];
          if (v_q[s-1]) st_q[s] <= st_q[s-1];
        end
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int s = 0; s < STAGES; s++) begin
      occ = occ + OW'(v_q[s]);
    end
  end

  assign occupancy_o     = occ;
  assign out_valid_o     = v_q[STAGES-1];
  assign result_o        = st_q[STAGES-1].res;
  assign mask_o          = st_q[STAGES-1].mask;
  assign ctrl_alu_fn_o   = st_q[STAGES-1].fn;
  assign ctrl_reg_idxw_o = st_q[STAGES-1].idx;
  assign ctrl_wid_o      = st_q[STAGES-1].wid;
  assign ctrl_wvd_o      = st_q[STAGES-1].wvd;
  assign ctrl_wxd_o      = st_q[STAGES-1].wxd;

endmodule

// File: doc/vec_mac_pipe.md
Name: vec_mac_pipe

Overview:
- Multi-lane integer multiply / multiply-accumulate unit for the SM vector pipeline (vmul); one instance serves a whole warp.
- Each of NUM_LANE lanes computes one XLEN result per accepted operation.
- Pipeline depth is configurable via STAGES. Every stage uses valid/ready with bubble collapsing, so a stall only halts the occupied stages behind it.
- Adds a synchronous flush for warp kill/branch recovery and an occupancy count for the issue scoreboard.

Parameters:
NUM_LANE, `NUM_THREAD, number of parallel lanes (>=1)
XLEN, `XLEN, operand/result width per lane (8..64)
STAGES, 2, pipeline register stages from input to output (1..8)
CW, `REGIDX_WIDTH+`REGEXT_WIDTH, destination register index width

Ports:
clk  in  1  clock
rst_n  in  1  reset
in_valid_i  in  1  operation valid
in_ready_o  out  1  unit accepts operation this cycle
a_i  in  NUM_LANE*XLEN  operand a, lane k at [k*XLEN +: XLEN]
b_i  in  NUM_LANE*XLEN  operand b
c_i  in  NUM_LANE*XLEN  operand c
mask_i  in  NUM_LANE  lane active mask
ctrl_alu_fn_i  in  6  function code, `FN_* encodings
ctrl_reg_idxw_i  in  CW  destination register
ctrl_wid_i  in  `DEPTH_WARP  warp id
ctrl_wvd_i  in  1  vector writeback
ctrl_wxd_i  in  1  scalar writeback
flush_i  in  1  discard all in-flight operations
out_valid_o  out  1  result valid
out_ready_i  in  1  downstream accepts
result_o  out  NUM_LANE*XLEN  per-lane result
mask_o, ctrl_alu_fn_o, ctrl_reg_idxw_o, ctrl_wid_o, ctrl_wvd_o, ctrl_wxd_o  out  (as inputs)  sideband delivered with result
occupancy_o  out  $clog2(STAGES+1)  number of valid stages

Behaviour:
Clock and reset:
- One clock, clk. Reset rst_n is asynchronous, active-low.
- On reset, every stage valid, data and sideband register clears to 0.
- Outputs after reset: out_valid_o=0, result_o=0, all sideband=0, occupancy_o=0, in_ready_o=1.

Lane arithmetic (computed combinationally at input, result then carried through the stages):
- Swap: for MADD/NMSUB, multiplicand m=c and addend d=a. For all other functions, m=a and d=c.
- Product P = m*b_i as a 2*XLEN product. Operand extension:
  - MULH: signed x signed.
  - MULHSU: m signed, b unsigned.
  - MUL, MULHU, and all MAC functions: unsigned x unsigned.
- Result:
  - MUL = P[XLEN-1:0]
  - MULH / MULHSU / MULHU = P[2*XLEN-1:XLEN]
  - MACC / MADD = d + P (low XLEN bits, wrap)
  - NMSAC / NMSUB = d - P (low XLEN bits, wrap)
  - Any other code = P[XLEN-1:0].
- Lanes with mask_i[k]=0 produce result 0. The mask itself is passed through unchanged.

Pipeline:
- Stage s holds valid v[s]. Stage STAGES-1 drives the outputs; out_valid_o = v[STAGES-1].
- Advance rules:
  - adv[STAGES-1] = !v[STAGES-1] | out_ready_i.
  - adv[s] = !v[s] | adv[s+1].
- When adv[s] is true, stage s loads from stage s-1 (stage 0 loads from the input), and v[s] takes the upstream valid.
- in_ready_o = adv[0] & !flush_i. An operation is accepted when in_valid_i & in_ready_o.
- Latency is exactly STAGES cycles from acceptance to out_valid_o when there is no stall. Throughput is 1 op/cycle with out_ready_i held high.
- Output data and sideband are stable while out_valid_o=1 and out_ready_i=0.
- A bubble in stage s is filled even while the output is stalled.
- Data registers update only when adv[s] is true and the upstream stage is valid.

Flush and occupancy:
- flush_i=1 clears all v[s] at the next edge. Flush beats a simultaneous input, and no operation is accepted that cycle.
- Data registers are not cleared by flush.
- In the flush cycle, out_valid_o still reflects the current state. A transfer that completes in that same cycle counts as delivered.
- occupancy_o = popcount(v) on registered state.
- STAGES=1: the single register is a skid-free pipe. in_ready_o = !v[0] | out_ready_i.

Test Plan:
- STAGES=2, lane0 a=0xFFFFFFFF b=2, mask=1, fn MUL/MULH/MULHSU/MULHU issued back-to-back, out_ready_i=1 -> results 0xFFFFFFFE, 0xFFFFFFFF, 0xFFFFFFFF, 0x00000001 on cycles 2,3,4,5 after first accept.
- a=3 b=4 c=5, fn MACC/NMSAC/MADD/NMSUB -> 17, 0xFFFFFFF9, 23, 0xFFFFFFEF; sideband (wid, reg_idxw, wvd, wxd) matches per op.
- mask=0b0101 over 4 lanes, all a=b=2, fn MUL -> lanes 0,2 = 4; lanes 1,3 = 0; mask_o=0b0101.
- Stall: STAGES=3, issue 5 ops, hold out_ready_i=0 for 6 cycles -> in_ready_o drops after 3 accepts, occupancy_o=3, output held constant. Release -> ops delivered in order with no loss or duplication.
- Bubble collapse: stage-1 empty, output stalled -> new input is still accepted; occupancy_o increments.
- flush_i pulsed with 2 ops in flight and in_valid_i=1 -> next cycle out_valid_o=0, occupancy_o=0, the input is not accepted. Reset asserted mid-stream -> all outputs 0 immediately.
